// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO (mult, multu, div, divu, mthi, mtlo, optional madd/maddu).
// Latency: arithmetic ops commit HI/LO MULT_CYCLES / DIV_CYCLES edges after acceptance; mthi/mtlo commit at the accepting edge.
// Backpressure: busy is high while an op is in flight; start during busy is dropped, nothing is queued. Optional feature: MDU_MADD_EN.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    // Operands and opcode are captured at acceptance so A/B may change freely while busy.
    logic [7:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    // Results computed from the latched operands, applied only at the completion edge.
    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        udvs;
    logic [31:0]        sdvs;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [31:0]        sq_mag;
    logic [31:0]        sr_mag;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_we;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        ok = (op >= OP_MULT) && (op <= OP_MTLO);
`ifdef MDU_MADD_EN
        ok = ok || (op == OP_MADD) || (op == OP_MADDU);
`endif
        return ok;
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    assign a_sx   = {{32{a_q[31]}}, a_q};
    assign b_sx   = {{32{b_q[31]}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    // A zero divisor is replaced by 1 to keep the dividers X-free; the result is discarded anyway.
    assign abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
    assign abs_b  = b_q[31] ? (32'd0 - b_q) : b_q;
    assign udvs   = (b_q == 32'd0) ? 32'd1 : b_q;
    assign sdvs   = (b_q == 32'd0) ? 32'd1 : abs_b;
    assign uq     = a_q / udvs;
    assign ur     = a_q % udvs;
    assign sq_mag = abs_a / sdvs;
    assign sr_mag = abs_a % sdvs;

    // Select the HI/LO value the in-flight op will commit, and whether it commits at all.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        res_we = 1'b0;
        case (op_q)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_we = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_we = 1'b1;
            end
            OP_DIV: begin
                res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - sq_mag) : sq_mag;
                res_hi = a_q[31] ? (32'd0 - sr_mag) : sr_mag;
                res_we = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res_lo = uq;
                res_hi = ur;
                res_we = (b_q != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                {res_hi, res_lo} = {hi, lo} + prod_s;
                res_we = 1'b1;
            end
            OP_MADDU: begin
                {res_hi, res_lo} = {hi, lo} + prod_u;
                res_we = 1'b1;
            end
`endif
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    // Accept requests when idle, count down in-flight ops, commit HI/LO when the count expires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= 1'b0;
            hi   <= 32'd0;
            lo   <= 32'd0;
            cnt  <= 8'd0;
            op_q <= 4'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (busy) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
                busy <= 1'b0;
                if (res_we) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end else if (start && op_legal(md_op)) begin
            case (md_op)
                OP_MTHI: hi <= A;
                OP_MTLO: lo <= A;
                default: begin
                    a_q  <= A;
                    b_q  <= B;
                    op_q <= md_op;
                    busy <= 1'b1;
                    cnt  <= op_is_div(md_op) ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
                end
            endcase
        end
    end

    assign md_out = hilo_sel ? hi : lo;

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit holding the HI/LO registers for the single-cycle MIPS datapath. It sits beside the ALU and feeds the register-file write-data mux: mfhi/mflo results leave on `md_out` and go to the GRF write port. `busy` goes to the control unit so the PC and GRF write-enable are stalled while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: cycles from acceptance to HI/LO update for mult/multu/madd/maddu; legal range 1..255.
- `DIV_CYCLES`, default 10: same for div/divu; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; state clears at a rising edge of `clk` when `reset`==0.
- `start`  in  1  request strobe; qualifies `md_op` for one cycle.
- `md_op`  in  4  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; any other value is a no-op.
- `A`  in  32  rs operand.
- `B`  in  32  rt operand.
- `hilo_sel`  in  1  0 selects LO onto `md_out`, 1 selects HI.
- `busy`  out  1  registered; high while an operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `md_out`  out  32  combinational: `hilo_sel` ? `hi` : `lo`.

## Operation
- Acceptance: a request is accepted at an edge where `reset`==1, `start`==1, `busy`==0 and `md_op` is legal. Any other `start` is ignored, with no state change.
- Accepting an arithmetic op (1–4, 7, 8):
  - latches `A`, `B` and `md_op`;
  - loads the countdown counter with `MULT_CYCLES` or `DIV_CYCLES`;
  - sets `busy`=1.
- Counter behaviour while `busy`==1:
  - decrements by 1 each edge;
  - at the edge where it would reach 0: HI/LO are written and `busy` clears in the same edge.
- mthi/mtlo (5, 6): write `A` into HI or LO at the accepting edge. Single cycle; `busy` stays 0.
- mult: {HI,LO} = signed 64-bit product of the latched operands.
- multu: {HI,LO} = unsigned 64-bit product.
- div (signed):
  - LO = quotient, truncated toward zero;
  - HI = remainder, carrying the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (B==0 for div/divu): full `DIV_CYCLES` latency still elapses; HI and LO are left unchanged.
- Operands are taken only from the latched copies, so `A`/`B` changes during `busy` have no effect.
- `hi`/`lo` outputs always show the committed registers; no intermediate values appear on them.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, counter=0; `md_out` is therefore 0.
- Arithmetic latency: acceptance at edge E0 → `busy` high from after E0 until edge E(N), where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - HI/LO change at E(N); `busy` reads 0 after E(N).
  - `busy` is high for exactly N cycles.
  - N=1: HI/LO update at E1.
- Back-to-back: `start` sampled in the cycle after E(N) (`busy`==0) is accepted, giving no dead cycle between operations.
- Reset mid-operation: `reset`==0 at any edge aborts the in-flight op. HI/LO are cleared, not updated, and `busy`=0 after that edge.
- `start` coincident with `reset`==0: reset wins and the request is dropped.
- `md_out` follows `hilo_sel`, `hi` and `lo` combinationally, with zero latency.
- Control is responsible for stalling mfhi/mflo and new md ops while `busy`. The unit itself does not queue requests.

## Configuration
- `MDU_MADD_EN` defined:
  - md_op 7 (madd) and 8 (maddu) are legal;
  - at completion, {HI,LO} += product (signed for 7, unsigned for 8), mod 2^64;
  - latency is `MULT_CYCLES`.
- `MDU_MADD_EN` undefined: md_op 7/8 are no-ops, so `start` with them has no effect and `busy` stays 0. No accumulate logic is compiled in.

## Test plan
- Reset then mult: `reset`=0 for 2 cycles, then start mult A=0xFFFFFFFE (-2), B=3.
  - Expect `busy` high for exactly 5 cycles.
  - Expect HI=0xFFFFFFFF, LO=0xFFFFFFFA at E5.
  - Expect `md_out`=LO when `hilo_sel`=0.
- divu then div:
  - divu A=100, B=7 → after 10 cycles LO=14, HI=2.
  - div A=-7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: mthi 0x11, mtlo 0x22 (each visible the next cycle, `busy` stays 0), then div A=5, B=0.
  - Expect `busy` high for 10 cycles.
  - Expect HI=0x11 and LO=0x22 unchanged.
- Ignored requests and reset abort:
  - During `busy` of multu 0x10000×0x10000, pulse mtlo and a second mult → both ignored; result HI=1, LO=0.
  - Next, start mult and assert `reset`=0 at cycle 3 → `busy`=0, HI=LO=0, no late write.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 → after 5 cycles HI=1, LO=0. Without the macro, the same stimulus leaves HI/LO unchanged and `busy`=0.
